// File: rtl/cpu_dbg_pkg.sv
// cpu_dbg_pkg: shared sequencer states, dump-beat record and default
// register-file sizes for the run/dump controller and debug read port.
package cpu_dbg_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int REG_CNT_DEF = 32;
  localparam int ADDR_W_DEF  = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOLD,
    S_RUN,
    S_RD,
    S_OUT,
    S_DONE
  } state_e;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] idx;
    logic [DATA_W_DEF-1:0] data;
  } dump_beat_t;

endpackage

// File: rtl/dump_stream_reg.sv
// dump_stream_reg: valid/ready holding register for one dump beat;
// load captures a beat, it is held until accepted, clear zeroes it.
module dump_stream_reg
  import cpu_dbg_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] idx_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic              fire_o,
  output logic [ADDR_W-1:0] idx_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] data_q, data_d;

  assign fire_o  = valid_q & ready_i;
  assign valid_o = valid_q;
  assign idx_o   = idx_q;
  assign data_o  = data_q;

  always_comb begin
    valid_d = valid_q;
    idx_d   = idx_q;
    data_d  = data_q;
    if (clr_i) begin
      valid_d = 1'b0;
      idx_d   = '0;
      data_d  = '0;
    end else if (load_i) begin
      valid_d = 1'b1;
      idx_d   = idx_i;
      data_d  = data_i;
    end else if (fire_o) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= 1'b0;
      idx_q   <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/cpu_run_dump_ctrl.sv
// cpu_run_dump_ctrl: reset/run the CPU for a fixed cycle count, then stream
// the register file out; CPU_RUN_DUMP_HALT_EN adds halt_i to end RUN early.
module cpu_run_dump_ctrl
  import cpu_dbg_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int REG_CNT    = REG_CNT_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int CNT_W      = 16,
  parameter int RUN_CYCLES = 15,
  parameter int RST_HOLD   = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
`ifdef CPU_RUN_DUMP_HALT_EN
  input  logic              halt_i,
`endif
  output logic              cpu_rst_n_o,
  output logic              cpu_run_o,
  output logic [ADDR_W-1:0] dbg_addr_o,
  input  logic [DATA_W-1:0] dbg_data_i,
  output logic              dump_valid_o,
  input  logic              dump_ready_i,
  output logic [ADDR_W-1:0] dump_idx_o,
  output logic [DATA_W-1:0] dump_data_o,
  output logic [CNT_W-1:0]  cycle_cnt_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int HW = $clog2(RST_HOLD + 1);
  localparam logic [HW-1:0]     HOLD_LAST = HW'(RST_HOLD - 1);
  localparam logic [CNT_W-1:0]  RUN_LAST  = CNT_W'(RUN_CYCLES - 1);
  localparam logic [ADDR_W-1:0] IDX_LAST  = ADDR_W'(REG_CNT - 1);

  state_e            state_q, state_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rst_n_q, run_q, busy_q, done_q;
  logic              load, clr, fire, halt;

`ifdef CPU_RUN_DUMP_HALT_EN
  assign halt = halt_i;
`else
  assign halt = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    clr     = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d = S_HOLD;
          hold_d  = '0;
          cnt_d   = '0;
          idx_d   = '0;
          clr     = 1'b1;
        end
      end
      S_HOLD: begin
        if (hold_q == HOLD_LAST) state_d = S_RUN;
        else hold_d = hold_q + 1'b1;
      end
      S_RUN: begin
        // the cycle that sees halt still counts as run
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == RUN_LAST || halt) begin
          state_d = S_RD;
          idx_d   = '0;
        end
      end
      S_RD: begin
        load    = 1'b1;
        state_d = S_OUT;
      end
      S_OUT: begin
        if (fire) begin
          if (idx_q == IDX_LAST) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_RD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      hold_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      rst_n_q <= 1'b0;
      run_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      rst_n_q <= state_d inside {S_RUN, S_RD, S_OUT, S_DONE};
      run_q   <= state_d == S_RUN;
      busy_q  <= state_d inside {S_HOLD, S_RUN, S_RD, S_OUT};
      done_q  <= state_d == S_DONE;
    end
  end

  dump_stream_reg #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_stream (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (clr),
    .load_i (load),
    .idx_i  (idx_q),
    .data_i (dbg_data_i),
    .ready_i(dump_ready_i),
    .valid_o(dump_valid_o),
    .fire_o (fire),
    .idx_o  (dump_idx_o),
    .data_o (dump_data_o)
  );

  assign dbg_addr_o  = idx_q;
  assign cpu_rst_n_o = rst_n_q;
  assign cpu_run_o   = run_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign cycle_cnt_o = cnt_q;

endmodule

// File: doc/cpu_run_dump_ctrl.md
Name: cpu_run_dump_ctrl

Overview:
Synthesizable run-and-dump sequencer for the 5-stage pipelined CPU.
- Holds the CPU in reset, then releases it and runs it for a programmable number of cycles.
- Freezes the CPU, then walks the register file through a debug read port and streams each (index, value) pair out over a valid/ready interface.
- Sits between the top-level harness and Pipe_CPU, in parallel with the register file's normal read ports.
- Generalises the fixed-count, display-all-registers run control into a parametrised, handshaked, restartable block.

Parameters:
DATA_W, 32, register width in bits
REG_CNT, 32, number of registers dumped (indices 0..REG_CNT-1)
ADDR_W, 5, debug address width; must satisfy 2**ADDR_W >= REG_CNT
CNT_W, 16, run-cycle counter width
RUN_CYCLES, 15, CPU-enabled cycles per run; range 1..2**CNT_W-1
RST_HOLD, 1, cycles cpu_rst_n_o is held low after start; must be >=1

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous active-low reset
start_i  in  1  launch a run; sampled in IDLE or DONE only
cpu_rst_n_o  out  1  active-low reset to the CPU
cpu_run_o  out  1  CPU clock-enable, high only in RUN
dbg_addr_o  out  ADDR_W  register-file debug read address
dbg_data_i  in  DATA_W  combinational register-file read data for dbg_addr_o
dump_valid_o  out  1  dump beat valid
dump_ready_i  in  1  dump sink ready
dump_idx_o  out  ADDR_W  register index of the current beat
dump_data_o  out  DATA_W  register value of the current beat
cycle_cnt_o  out  CNT_W  RUN cycles elapsed in the current/last run
busy_o  out  1  high in HOLD, RUN, RD, OUT
done_o  out  1  high in DONE

Behaviour:
- States: IDLE, HOLD, RUN, RD, OUT, DONE.
- Reset (rst_i low, asynchronous): state IDLE; cpu_rst_n_o=0, cpu_run_o=0, dump_valid_o=0, dump_idx_o=0, dump_data_o=0, dbg_addr_o=0, cycle_cnt_o=0, busy_o=0, done_o=0. Reset mid-run or mid-dump aborts immediately with no partial completion.
- IDLE:
  - cpu_rst_n_o=0.
  - start_i=1 -> HOLD; hold counter and cycle_cnt_o cleared.
- HOLD:
  - cpu_rst_n_o=0 for exactly RST_HOLD cycles, then -> RUN.
  - start_i is ignored.
- RUN:
  - cpu_rst_n_o=1, cpu_run_o=1.
  - cycle_cnt_o increments each cycle.
  - After exactly RUN_CYCLES cycles, cycle_cnt_o==RUN_CYCLES -> RD, with index=0.
  - cpu_run_o is 1 for exactly RUN_CYCLES consecutive cycles.
- RD:
  - cpu_run_o=0 and cpu_rst_n_o=1, so the CPU is frozen with its state preserved.
  - dbg_addr_o=index.
  - Next edge: dump_data_o<=dbg_data_i, dump_idx_o<=index -> OUT.
- OUT:
  - dump_valid_o=1; data and idx are held stable until the handshake.
  - Handshake on dump_valid_o & dump_ready_i at an edge.
  - On handshake: if index==REG_CNT-1 -> DONE, else index+1 -> RD.
  - dump_valid_o never depends combinationally on dump_ready_i.
  - Minimum 2 cycles per register; indefinite backpressure is legal.
- DONE:
  - done_o=1; cpu_rst_n_o stays 1; cycle_cnt_o holds its value.
  - start_i=1 -> HOLD (restart; CPU is reset again).
- start_i is ignored in every state except IDLE and DONE.
- Index wrap: the index never exceeds REG_CNT-1. When REG_CNT < 2**ADDR_W, the unused addresses are never presented.
- Counter: cycle_cnt_o never wraps within a run, given the RUN_CYCLES range constraint.
- All outputs are registered except dbg_addr_o, which may be a decode of state/index.

Optional Feature:
Macro CPU_RUN_DUMP_HALT_EN adds input port halt_i (1 bit, CPU halt indication).
- With the macro: halt_i=1 during RUN ends RUN at that edge. The halting cycle counts, so cycle_cnt_o = cycles actually run, which is <= RUN_CYCLES. Flow then proceeds to RD as normal. halt_i is ignored outside RUN.
- Without the macro: the port is absent and RUN always lasts RUN_CYCLES cycles.

Decomposition:
Shared package cpu_dbg_pkg holds:
- state enum constants for IDLE/HOLD/RUN/RD/OUT/DONE;
- the dump-beat record (idx, data) typedef;
- default DATA_W/REG_CNT/ADDR_W constants shared with the register file.

One natural sub-module, dump_stream_reg: the OUT-stage valid/ready holding register, with load, hold-until-accept and clear. The FSM and counters stay in the top.

Test Plan:
- Defaults; RF model returns value 100+addr; start_i pulse; sink always ready -> cpu_rst_n_o low 1 cycle, cpu_run_o high exactly 15 cycles, cycle_cnt_o=15, 32 beats with idx 0..31 and data 100..131 in order, then done_o=1.
- Sink ready toggles 1-in-3 cycles -> same 32 beats, no drops or duplicates, data and idx stable whenever valid is high and ready is low.
- rst_i pulled low during OUT at idx=7 -> all outputs at reset values immediately (asynchronous); after release, no beats until a new start_i.
- REG_CNT=8, RUN_CYCLES=3, RST_HOLD=4 -> reset low for 4 cycles, run for 3 cycles, beats idx 0..7 only, done_o after the 8th handshake.
- start_i held high throughout RUN, then re-pulsed in DONE -> no effect during RUN; in DONE, restarts with cpu_rst_n_o low again and cycle_cnt_o cleared to 0.
- With CPU_RUN_DUMP_HALT_EN, halt_i=1 on the 6th RUN cycle -> cycle_cnt_o=6 and cpu_run_o drops after that cycle; dump proceeds normally.
